uart_tx_fifo_gen: RTL and testbench



---
 rtl/uart_tx_fifo_gen.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_tx_fifo_gen.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_gen.sv
// UART transmitter with an integrated transmit FIFO: 5-8 data bits, optional
// parity, one or two stop bits, line break, and gapless back-to-back frames.
module uart_tx_fifo_gen #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             xmit_pulse,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic [1:0]       data_len,
  input  logic             parity_en,
  input  logic             odd_n_even,
  input  logic             stop2,
  input  logic             send_break,
  output logic             tx,
  output logic             tx_busy,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow
);

  localparam int unsigned      AW        = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOADED,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_BRKWAIT,
    S_BREAK
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             push;
  logic             pop;

  // Transmitter state and per-frame latched configuration
  state_t           state_q, state_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [7:0]       char_q, char_d;
  logic [3:0]       nbits_q, nbits_d;
  logic             par_en_q, par_en_d;
  logic             odd_q, odd_d;
  logic             stop2_q, stop2_d;
  logic [3:0]       idx_q, idx_d;
  logic             frame_end;

  logic [7:0]       head_data;
  logic [7:0]       len_mask;
  logic [3:0]       len_bits;
  logic             parity_bit;

  assign head_data  = mem_q[rd_ptr_q];
  assign len_mask   = 8'hFF >> (2'd3 - data_len);
  assign len_bits   = {2'b00, data_len} + 4'd5;
  // Unused high bits are cleared at pop time, so a full-width XOR is exact.
  assign parity_bit = (^char_q) ^ odd_q;

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    idx_d     = idx_q;
    char_d    = char_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    odd_d     = odd_q;
    stop2_d   = stop2_q;
    pop       = 1'b0;
    frame_end = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (send_break) begin
          state_d = S_BRKWAIT;
        end else if (!empty_q) begin
          pop     = 1'b1;
          state_d = S_LOADED;
        end
      end
      S_LOADED: begin
        if (xmit_pulse) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (xmit_pulse) begin
          tx_d    = char_q[0];
          idx_d   = 4'd1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xmit_pulse) begin
          if (idx_q < nbits_q) begin
            tx_d  = char_q[idx_q[2:0]];
            idx_d = idx_q + 4'd1;
          end else if (par_en_q) begin
            tx_d    = parity_bit;
            state_d = S_PARITY;
          end else begin
            tx_d    = 1'b1;
            state_d = S_STOP1;
          end
        end
      end
      S_PARITY: begin
        if (xmit_pulse) begin
          tx_d    = 1'b1;
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (xmit_pulse) begin
          if (stop2_q) begin
            tx_d    = 1'b1;
            state_d = S_STOP2;
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      S_STOP2: begin
        if (xmit_pulse) begin
          frame_end = 1'b1;
        end
      end
      S_BRKWAIT: begin
        if (xmit_pulse) begin
          tx_d    = 1'b0;
          state_d = S_BREAK;
        end
      end
      S_BREAK: begin
        // Leaving break always costs one mark bit via a single-stop STOP1.
        if (xmit_pulse && !send_break) begin
          tx_d    = 1'b1;
          stop2_d = 1'b0;
          state_d = S_STOP1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (frame_end) begin
      if (!empty_q && !send_break) begin
        pop     = 1'b1;
        tx_d    = 1'b0;
        state_d = S_START;
      end else begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    end

    if (pop) begin
      char_d   = head_data & len_mask;
      nbits_d  = len_bits;
      par_en_d = parity_en;
      odd_d    = odd_n_even;
      stop2_d  = stop2;
    end

    busy_d = (state_d != S_IDLE);
  end

  // A write into a full FIFO still lands when the head leaves in the same cycle.
  always_comb begin
    push     = wr_en && (!full_q || pop);
    ovf_d    = wr_en && !push;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      char_q   <= '0;
      nbits_q  <= '0;
      par_en_q <= 1'b0;
      odd_q    <= 1'b0;
      stop2_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      char_q   <= char_d;
      nbits_q  <= nbits_d;
      par_en_q <= par_en_d;
      odd_q    <= odd_d;
      stop2_q  <= stop2_d;
      idx_q    <= idx_d;
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo_gen.sv
// Scoreboard bench for uart_tx_fifo_gen: expected line bits are queued per
// write; a monitor compares tx at every bit boundary while the transmitter is busy.
module tb_uart_tx_fifo_gen;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          xmit_pulse;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic [1:0]    data_len;
  logic          parity_en;
  logic          odd_n_even;
  logic          stop2;
  logic          send_break;
  logic          tx;
  logic          tx_busy;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  uart_tx_fifo_gen #(
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .xmit_pulse(xmit_pulse),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .data_len  (data_len),
    .parity_en (parity_en),
    .odd_n_even(odd_n_even),
    .stop2     (stop2),
    .send_break(send_break),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned ovf_cnt  = 0;
  int unsigned bit_no   = 0;
  int unsigned pcnt     = 0;
  logic        pulse_en = 1'b1;
  logic        busy_prev = 1'b0;
  logic        exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, req, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=timeout required=event @%0t", name, $time);
  endtask

  task automatic push_bit(input logic b);
    exp_q.push_back(b);
  endtask

  // Reference frame: start, N data bits LSB first, optional parity, stop bit(s).
  task automatic push_frame(input logic [7:0] d, input logic [1:0] len,
                            input logic pe, input logic odd, input logic s2);
    int unsigned n;
    logic        p;
    n = 5 + int'(len);
    p = odd;
    exp_q.push_back(1'b0);
    for (int unsigned i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pe) exp_q.push_back(p);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_tx(input logic val, input int unsigned budget, input string name);
    logic seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (tx === val) seen = 1'b1;
    end
    if (!seen) fail_timeout(name);
  endtask

  task automatic wait_idle(input int unsigned budget, input string name);
    logic seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (tx_busy === 1'b0) seen = 1'b1;
    end
    if (!seen) fail_timeout(name);
  endtask

  task automatic wait_drain(input int unsigned budget, input string name);
    logic seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) seen = 1'b1;
    end
    if (!seen) fail_timeout(name);
  endtask

  task automatic wait_pulses(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      logic seen = 1'b0;
      for (int unsigned c = 0; c < 64 && !seen; c++) begin
        @(posedge clk);
        #1;
        if (xmit_pulse) seen = 1'b1;
      end
      if (!seen) fail_timeout("xmit_pulse");
    end
  endtask

  task automatic wait_count_change(input logic [CW-1:0] req, input int unsigned budget,
                                   input string name);
    logic [CW-1:0] prev;
    logic          seen = 1'b0;
    @(negedge clk);
    prev = fifo_count;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (fifo_count !== prev) seen = 1'b1;
    end
    if (!seen) fail_timeout(name);
    else check(name, 32'(fifo_count), 32'(req));
  endtask

  // Baud strobe: one clk every 16, driven on the falling edge.
  initial begin
    xmit_pulse = 1'b0;
    forever begin
      @(negedge clk);
      pcnt++;
      xmit_pulse = pulse_en && (pcnt % 16 == 0);
    end
  end

  // Monitor: each bit-period boundary taken by a busy transmitter yields one line bit.
  initial begin
    logic e;
    forever begin
      @(posedge clk);
      #1;
      if (overflow === 1'b1) ovf_cnt++;
      if (!reset && xmit_pulse && busy_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_extra actual=%0b required=no_bit @%0t", tx, $time);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("tx_bit%0d", bit_no), 32'(tx), 32'(e));
          bit_no++;
        end
      end
      busy_prev = tx_busy;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ovf_base;
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_data    = '0;
    data_len   = 2'b11;
    parity_en  = 1'b0;
    odd_n_even = 1'b0;
    stop2      = 1'b0;
    send_break = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tx",    32'(tx),         32'd1);
    check("rst_busy",  32'(tx_busy),    32'd0);
    check("rst_full",  32'(fifo_full),  32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf",   32'(overflow),   32'd0);
    reset = 1'b0;

    // 0x55, 8N1, plus push/pop latency
    push_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0);
    push_bit(1'b1);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'h55;
    @(posedge clk);
    #1;
    check("lat_count_c1", 32'(fifo_count), 32'd1);
    check("lat_empty_c1", 32'(fifo_empty), 32'd0);
    check("lat_busy_c1",  32'(tx_busy),    32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    check("lat_count_c2", 32'(fifo_count), 32'd0);
    check("lat_busy_c2",  32'(tx_busy),    32'd1);
    wait_drain(400, "drain_55");
    check("idle_busy_55", 32'(tx_busy), 32'd0);
    check("idle_tx_55",   32'(tx),      32'd1);

    // 5 bits, even parity, two stops; then odd parity with masked high bits
    data_len   = 2'b00;
    parity_en  = 1'b1;
    odd_n_even = 1'b0;
    stop2      = 1'b1;
    push_frame(8'h1F, 2'b00, 1'b1, 1'b0, 1'b1);
    push_bit(1'b1);
    write_byte(8'h1F);
    wait_drain(400, "drain_1f");
    odd_n_even = 1'b1;
    push_frame(8'hE0, 2'b00, 1'b1, 1'b1, 1'b1);
    push_bit(1'b1);
    write_byte(8'hE0);
    wait_drain(400, "drain_e0");

    // 7E1 back-to-back: first byte pops at once, three stay queued
    data_len   = 2'b10;
    parity_en  = 1'b1;
    odd_n_even = 1'b0;
    stop2      = 1'b0;
    push_frame(8'hC3, 2'b10, 1'b1, 1'b0, 1'b0);
    push_frame(8'h2A, 2'b10, 1'b1, 1'b0, 1'b0);
    push_frame(8'h7F, 2'b10, 1'b1, 1'b0, 1'b0);
    push_frame(8'h00, 2'b10, 1'b1, 1'b0, 1'b0);
    push_bit(1'b1);
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hC3;
    @(negedge clk); wr_data = 8'h2A;
    @(negedge clk); wr_data = 8'h7F;
    @(negedge clk); wr_data = 8'h00;
    @(posedge clk);
    #1;
    check("b2b_count3", 32'(fifo_count), 32'd3);
    @(negedge clk);
    wr_en = 1'b0;
    wait_count_change(CW'(2), 400, "b2b_count2");
    wait_count_change(CW'(1), 400, "b2b_count1");
    wait_count_change(CW'(0), 400, "b2b_count0");
    wait_drain(400, "drain_b2b");

    // break requested mid-frame; queued frame follows after one mark bit
    data_len   = 2'b11;
    parity_en  = 1'b0;
    stop2      = 1'b0;
    push_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0);
    push_bit(1'b1);
    repeat (4) push_bit(1'b0);
    push_bit(1'b1);
    push_frame(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0);
    push_bit(1'b1);
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h3C;
    @(negedge clk); wr_data = 8'hC3;
    @(negedge clk); wr_en = 1'b0;
    wait_tx(1'b0, 64, "brk_start");
    wait_pulses(3);
    @(negedge clk);
    send_break = 1'b1;
    wait_idle(300, "brk_frame_end");
    wait_tx(1'b0, 64, "brk_line_low");
    check("brk_queue_held", 32'(fifo_count), 32'd1);
    wait_pulses(3);
    @(negedge clk);
    send_break = 1'b0;
    wait_drain(600, "drain_brk");

    // reset during data bit 3 discards the frame and the queued byte
    push_bit(1'b0);
    push_bit(1'b1);
    push_bit(1'b0);
    push_bit(1'b1);
    push_bit(1'b0);
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk); wr_data = 8'h0F;
    @(negedge clk); wr_en = 1'b0;
    wait_tx(1'b0, 64, "rst_mid_start");
    wait_pulses(4);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tx",    32'(tx),           32'd1);
    check("midrst_count", 32'(fifo_count),   32'd0);
    check("midrst_empty", 32'(fifo_empty),   32'd1);
    check("midrst_busy",  32'(tx_busy),      32'd0);
    check("midrst_sb",    32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("postrst_busy", 32'(tx_busy), 32'd0);
    check("postrst_tx",   32'(tx),      32'd1);

    // overflow: stall the baud strobe, hold one frame in LOADED, overfill by one
    @(posedge clk);
    #2;
    pulse_en = 1'b0;
    ovf_base = ovf_cnt;
    for (int unsigned i = 0; i <= DEPTH; i++) begin
      push_frame(8'(i * 29 + 7), 2'b11, 1'b0, 1'b0, 1'b0);
    end
    push_bit(1'b1);
    write_byte(8'd7);
    repeat (3) @(negedge clk);
    check("ovf_loaded_busy",  32'(tx_busy),    32'd1);
    check("ovf_loaded_count", 32'(fifo_count), 32'd0);
    for (int unsigned i = 1; i <= DEPTH + 1; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = (i == DEPTH + 1) ? 8'hA5 : 8'(i * 29 + 7);
    end
    @(negedge clk);
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    check("ovf_count", 32'(fifo_count),        32'(DEPTH));
    check("ovf_full",  32'(fifo_full),         32'd1);
    check("ovf_empty", 32'(fifo_empty),        32'd0);
    check("ovf_pulse", 32'(ovf_cnt - ovf_base), 32'd1);
    @(posedge clk);
    #2;
    pulse_en = 1'b1;
    wait_drain(4000, "drain_ovf");
    check("end_busy",  32'(tx_busy),    32'd0);
    check("end_count", 32'(fifo_count), 32'd0);
    check("end_empty", 32'(fifo_empty), 32'd1);
    check("end_full",  32'(fifo_full),  32'd0);
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
